// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS32 pipeline: the stall/flush sequencer
// state type, the architectural zero register, the bubble encoding loaded into
// pipeline registers on a flush, and the bundle of hazard control signals.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

   // Sequencer states: normal flow, or frozen behind a slow data-memory access.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } ctrl_state_e;

   // r0 is hard-wired to zero, so it never carries a real dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Per-stage control bits carried down the pipeline registers.
   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } stage_ctrl_t;

   // A bubble is an instruction with every control bit cleared: it writes
   // nothing, touches no memory and redirects nothing.
   localparam stage_ctrl_t BUBBLE_CTRL = '0;

   // Hazard controls produced by pipeline_ctrl each cycle.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
      logic pc_sel;
      logic dmem_req;
   } hz_ctrl_t;

   // Free-flowing pipeline: everything loads, nothing is flushed.
   localparam hz_ctrl_t HZ_DEFAULT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                       exmem_en: 1'b1, default: 1'b0};

   // Memory freeze: hold PC through EX/MEM, push a bubble into MEM/WB while the
   // access is outstanding.
   localparam hz_ctrl_t HZ_FREEZE  = '{memwb_flush: 1'b1, dmem_req: 1'b1, default: 1'b0};

   // Everything deasserted (used while reset is held).
   localparam hz_ctrl_t HZ_OFF     = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare. Flags when the instruction in ID needs
// a register that the load currently in ID/EX has not yet produced.
// Ports:
//   id_rs, id_rt   in  source register fields of the ID instruction
//   id_uses_rt     in  ID instruction actually reads rt
//   idex_memread   in  ID/EX holds a load
//   idex_rt        in  destination register of that load
//   load_use       out one-cycle stall required
// -----------------------------------------------------------------------------
module hazard_detect
   import mips_pipe_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   output logic       load_use
);

   // A load into r0 produces nothing, so it can never create a dependency.
   assign load_use = idex_memread
                  && (idex_rt != REG_ZERO)
                  && ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage MIPS32 pipeline. Resolves
// memory waits (highest priority), control transfers resolved in MEM, and
// load-use hazards, and keeps saturating stall/flush performance counters.
// All control outputs are combinational from state and current inputs.
// Parameters:
//   MAX_WAIT  data-memory wait cycles tolerated before timeout (1..255)
//   CNT_W     performance counter width
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt           ID instruction operands
//   idex_memread/idex_rt             load in ID/EX
//   exmem_branch/zero/jump           control transfer in EX/MEM
//   exmem_memread/memwrite           memory access in EX/MEM
//   dmem_ready                       data memory completes this cycle
//   dmem_req                         data memory request
//   pc_en/ifid_en/idex_en/exmem_en   register load enables
//   *_flush                          load bubble into the register
//   pc_sel                           select branch/jump target
//   mem_err                          sticky data-memory timeout
//   stall_cnt/flush_cnt              saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_jump,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             pc_sel,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   ctrl_state_e      state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   hz_ctrl_t ctrl;
   logic     mem;
   logic     taken;
   logic     load_use;

   assign mem   = exmem_memread | exmem_memwrite;
   assign taken = (exmem_branch & exmem_zero) | exmem_jump;

   hazard_detect u_hazard_detect (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .load_use     (load_use)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skipped an assignment would infer a latch.
      ctrl        = HZ_DEFAULT;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (reset) begin
         ctrl = HZ_OFF;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem) begin
                  ctrl.dmem_req = 1'b1;
               end
               if (mem && !dmem_ready) begin
                  // First cycle of a slow access already counts as wait cycle 1.
                  ctrl       = HZ_FREEZE;
                  state_d    = ST_MEM_WAIT;
                  wait_cnt_d = 8'd1;
               end else if (taken) begin
                  // Kill the three younger instructions; load-use is moot.
                  ctrl.pc_sel      = 1'b1;
                  ctrl.ifid_flush  = 1'b1;
                  ctrl.idex_flush  = 1'b1;
                  ctrl.exmem_flush = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en      = 1'b0;
                  ctrl.ifid_en    = 1'b0;
                  ctrl.idex_flush = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               // The request stays up until the cycle the access retires; the
               // release cycle itself lets the pipeline advance unconditionally,
               // and a pending load-use is picked up in the following RUN cycle.
               ctrl.dmem_req = 1'b1;
               if (dmem_ready) begin
                  state_d    = ST_RUN;
                  wait_cnt_d = 8'd0;
               end else if (wait_cnt_q >= MAX_WAIT_C) begin
                  mem_err_d  = 1'b1;
                  state_d    = ST_RUN;
                  wait_cnt_d = 8'd0;
               end else begin
                  ctrl       = HZ_FREEZE;
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            default: begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end
         endcase

         if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if (ctrl.pc_sel && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before this edge, independent of statement order.
      if (reset) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign dmem_req    = ctrl.dmem_req;
   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_flush = ctrl.exmem_flush;
   assign memwb_flush = ctrl.memwb_flush;
   assign pc_sel      = ctrl.pc_sel;
   assign mem_err     = mem_err_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl (MAX_WAIT = 4, CNT_W = 4). Expected
// control outputs are queued when stimulus is driven and compared on the
// falling edge; counters are tracked by a small saturating model.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   // Packed in the same order as the expected-value bit strings below:
   // pc_en ifid_en idex_en exmem_en | ifid_fl idex_fl exmem_fl memwb_fl | pc_sel dmem_req
   typedef struct packed {
      logic pc_en, ifid_en, idex_en, exmem_en;
      logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
      logic pc_sel, dmem_req;
   } out_t;

   typedef struct packed {
      logic [4:0] rs, rt;
      logic       uses_rt, idex_mr;
      logic [4:0] idex_rt;
      logic       br, zero, jmp, mr, mw, rdy;
   } in_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } vec_t;

   typedef struct {
      string name;
      out_t  exp;
      out_t  mask;
   } sb_item_t;

   localparam out_t O_DEF  = out_t'(10'b1111_0000_00);
   localparam out_t O_REQ  = out_t'(10'b1111_0000_01);
   localparam out_t O_LU   = out_t'(10'b0011_0100_00);
   localparam out_t O_LUR  = out_t'(10'b0011_0100_01);
   localparam out_t O_TK   = out_t'(10'b1111_1110_10);
   localparam out_t O_FRZ  = out_t'(10'b0000_0001_01);
   localparam out_t O_RST  = out_t'(10'b0000_0000_00);
   localparam out_t M_ALL  = out_t'(10'b1111_1111_11);
   localparam out_t M_NREQ = out_t'(10'b1111_1111_10);   // release cycle: dmem_req not compared

   logic clk, reset;
   logic [4:0] id_rs, id_rt, idex_rt;
   logic id_uses_rt, idex_memread;
   logic exmem_branch, exmem_zero, exmem_jump, exmem_memread, exmem_memwrite, dmem_ready;
   logic dmem_req, pc_en, ifid_en, idex_en, exmem_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int m_stall = 0;
   int m_flush = 0;
   sb_item_t sb_q[$];

   pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .exmem_jump(exmem_jump),
      .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .pc_sel(pc_sel), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic idex_mr, input logic [4:0] irt,
                              input logic br, input logic zero, input logic jmp,
                              input logic mr, input logic mw, input logic rdy);
      in_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.idex_mr = idex_mr; v.idex_rt = irt;
      v.br = br; v.zero = zero; v.jmp = jmp; v.mr = mr; v.mw = mw; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
      idex_memread = v.idex_mr; idex_rt = v.idex_rt;
      exmem_branch = v.br; exmem_zero = v.zero; exmem_jump = v.jmp;
      exmem_memread = v.mr; exmem_memwrite = v.mw; dmem_ready = v.rdy;
   endtask

   task automatic compare_out();
      sb_item_t it;
      out_t act;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      it  = sb_q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
             exmem_flush, memwb_flush, pc_sel, dmem_req};
      check({it.name, " ctrl"}, 32'(act & it.mask), 32'(it.exp & it.mask));
   endtask

   // One clock: drive just after a rising edge, compare controls on the falling
   // edge, then compare the counters against the model after the next edge.
   task automatic step(input string name, input in_t v, input out_t exp, input out_t mask);
      sb_item_t it;
      drive(v);
      it.name = name; it.exp = exp; it.mask = mask;
      sb_q.push_back(it);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
      if (reset) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!exp.pc_en && m_stall != CNT_MAX) m_stall++;
         if (exp.pc_sel && m_flush != CNT_MAX) m_flush++;
      end
      check({name, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      check({name, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
   endtask

   task automatic do_reset(input in_t v);
      reset = 1'b1;
      step("reset", v, O_RST, M_ALL);
      check("reset mem_err", 32'(mem_err), 32'd0);
      reset = 1'b0;
   endtask

   in_t  IDLE, LU8, MEMRD;
   vec_t tbl[$];

   initial begin
      IDLE  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      LU8   = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      MEMRD = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      //                         rs     rt   urt  imr  irt   br  zr  jmp  mr  mw  rdy
      tbl.push_back('{"idle",     IDLE, O_DEF});
      tbl.push_back('{"lu_rs",    LU8, O_LU});
      tbl.push_back('{"lu_r0",    mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF});
      tbl.push_back('{"lu_rt",    mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_LU});
      tbl.push_back('{"rt_unused",mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF});
      tbl.push_back('{"no_load",  mk(5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF});
      tbl.push_back('{"br_taken", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_TK});
      tbl.push_back('{"br_ntaken",mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF});
      tbl.push_back('{"zero_only",mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF});
      tbl.push_back('{"jump",     mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), O_TK});
      tbl.push_back('{"tk_vs_lu", mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_TK});
      tbl.push_back('{"ld_ready", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), O_REQ});
      tbl.push_back('{"st_rdy_lu",mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), O_LUR});
      tbl.push_back('{"rdy_no_req",mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_DEF});

      reset = 1'b1;
      drive(IDLE);
      @(posedge clk);
      #1;

      // Reset forces every control low even with every hazard source active.
      do_reset(mk(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));

      // Single-cycle RUN behaviour from the vector table.
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].name, tbl[i].in, tbl[i].exp, M_ALL);
      end

      // Multi-cycle load: 3 not-ready cycles frozen, release on the 4th. A
      // load-use held across the freeze is taken in the first RUN cycle.
      do_reset(IDLE);
      begin
         in_t v;
         v = MEMRD; v.rs = 5'd8; v.idex_mr = 1'b1; v.idex_rt = 5'd8;
         for (int i = 0; i < 3; i++) step("ld_wait", v, O_FRZ, M_ALL);
         v.rdy = 1'b1;
         step("ld_release", v, O_DEF, M_NREQ);
         v.mr = 1'b0; v.rdy = 1'b0;
         step("ld_lu_after", v, O_LU, M_ALL);
         step("ld_idle", IDLE, O_DEF, M_ALL);
         check("ld mem_err", 32'(mem_err), 32'd0);
      end

      // Timeout: dmem_ready never comes; four frozen cycles, then release with mem_err.
      do_reset(IDLE);
      for (int i = 0; i < MAX_WAIT; i++) step("to_wait", MEMRD, O_FRZ, M_ALL);
      check("to mem_err before", 32'(mem_err), 32'd0);
      step("to_release", MEMRD, O_DEF, M_NREQ);
      check("to mem_err set", 32'(mem_err), 32'd1);
      for (int i = 0; i < 3; i++) step("to_after", IDLE, O_DEF, M_ALL);
      check("to mem_err sticky", 32'(mem_err), 32'd1);
      do_reset(IDLE);
      check("to mem_err cleared", 32'(mem_err), 32'd0);

      // Ready arriving exactly at the limit is a success.
      for (int i = 0; i < MAX_WAIT; i++) step("edge_wait", MEMRD, O_FRZ, M_ALL);
      begin
         in_t v;
         v = MEMRD; v.rdy = 1'b1;
         step("edge_release", v, O_DEF, M_NREQ);
      end
      check("edge mem_err", 32'(mem_err), 32'd0);
      step("edge_idle", IDLE, O_DEF, M_ALL);

      // Reset in the 2nd wait cycle aborts the wait; back in RUN afterwards.
      do_reset(IDLE);
      step("rw_wait0", MEMRD, O_FRZ, M_ALL);
      reset = 1'b1;
      step("rw_reset", MEMRD, O_RST, M_ALL);
      reset = 1'b0;
      check("rw mem_err", 32'(mem_err), 32'd0);
      step("rw_run_idle", IDLE, O_DEF, M_ALL);
      // A fresh slow access now gets the full wait budget from RUN.
      for (int i = 0; i < MAX_WAIT; i++) step("rw_wait", MEMRD, O_FRZ, M_ALL);
      step("rw_release", MEMRD, O_DEF, M_NREQ);
      check("rw mem_err timeout", 32'(mem_err), 32'd1);

      // Counter saturation at 4 bits.
      do_reset(IDLE);
      for (int i = 0; i < 20; i++) step("sat_stall", LU8, O_LU, M_ALL);
      check("sat stall_cnt", 32'(stall_cnt), 32'd15);
      for (int i = 0; i < 20; i++) begin
         step("sat_flush", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
              O_TK, M_ALL);
      end
      check("sat flush_cnt", 32'(flush_cnt), 32'd15);

      if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
